// File: rtl/ixc_gfifo_sched.sv
// ixc_gfifo_sched: round-robin, credit-checked burst scheduler for the shared GFIFO write port
module ixc_gfifo_sched #(
  parameter int NREQ  = 4,
  parameter int DW    = 64,
  parameter int DEPTH = 256,
  parameter int LENW  = 9
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*LENW-1:0]       req_len,
  input  logic [NREQ-1:0]            req_dvalid,
  input  logic [NREQ*DW-1:0]         req_data,
  output logic [NREQ-1:0]            req_gnt,
  output logic [NREQ-1:0]            req_ack,
  input  logic [63:0]                rdCnt,
  output logic                       fifo_wr,
  output logic [DW-1:0]              fifo_wdata,
  output logic [$clog2(NREQ)-1:0]    fifo_tag,
  output logic [63:0]                wrCnt,
  output logic                       len_err,
  output logic                       ovf_err
);
  localparam int TAGW = $clog2(NREQ);
  typedef enum logic {S_IDLE, S_XFER} state_t;
  state_t r_state, w_state_n;
  logic [TAGW-1:0] r_g, w_g_n, r_rr, w_rr_n, w_pick, w_idx, r_tag;
  logic [LENW-1:0] r_remain, w_remain_n;
  logic [NREQ-1:0] r_gnt, w_gnt_n, w_elig, w_bad;
  logic [63:0]     r_rdcnt, r_wrcnt, w_occ, w_free;
  logic [DW-1:0]   r_wdata;
  logic            w_ovf, w_found, w_ack, r_fifo_wr, r_len_err, r_ovf_err;
  logic [LENW-1:0] w_len [NREQ];
  logic [DW-1:0]   w_data [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_src
    assign w_len[i]  = req_len[i*LENW +: LENW];
    assign w_data[i] = req_data[i*DW +: DW];
    assign w_bad[i]  = req_valid[i] && (w_len[i] == '0 || 32'(w_len[i]) > 32'(DEPTH));
    assign w_elig[i] = req_valid[i] && !w_bad[i] && 64'(w_len[i]) <= w_free;
  end

  // Occupancy counts words already in the write pipe, so the credit check is conservative
  assign w_occ = r_wrcnt - r_rdcnt;
  assign w_ovf = w_occ > 64'(DEPTH);
  assign w_free = w_ovf ? '0 : 64'(DEPTH) - w_occ;
  assign req_gnt = r_gnt;
  assign req_ack = r_gnt & req_dvalid;
  assign w_ack = |req_ack;
  assign fifo_wr = r_fifo_wr;
  assign fifo_wdata = r_wdata;
  assign fifo_tag = r_tag;
  assign wrCnt = r_wrcnt;
  assign len_err = r_len_err;
  assign ovf_err = r_ovf_err;

  // Round-robin pick: lowest offset from rr wins, so scan offsets from high to low
  always_comb begin
    w_found = 1'b0;
    w_pick = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = TAGW'((int'(r_rr) + k) % NREQ);
      if (w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // Grant FSM next state: IDLE latches a winner, XFER counts acks down to the last word
  always_comb begin
    w_state_n = r_state;
    w_g_n = r_g;
    w_rr_n = r_rr;
    w_remain_n = r_remain;
    w_gnt_n = r_gnt;
    if (r_state == S_IDLE && w_found) begin
      w_state_n = S_XFER;
      w_g_n = w_pick;
      w_rr_n = TAGW'((int'(w_pick) + 1) % NREQ);
      w_remain_n = w_len[w_pick];
      w_gnt_n = NREQ'(1) << w_pick;
    end else if (r_state == S_XFER && w_ack) begin
      w_remain_n = r_remain - LENW'(1);
      w_state_n = (r_remain == LENW'(1)) ? S_IDLE : S_XFER;
      w_gnt_n = (r_remain == LENW'(1)) ? '0 : r_gnt;
    end
  end

  // Grant FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_g <= '0;
      r_rr <= '0;
      r_remain <= '0;
      r_gnt <= '0;
    end else begin
      r_state <= w_state_n;
      r_g <= w_g_n;
      r_rr <= w_rr_n;
      r_remain <= w_remain_n;
      r_gnt <= w_gnt_n;
    end
  end

  // Credit counters, sticky errors and the one-stage GFIFO write pipe
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rdcnt <= '0;
      r_wrcnt <= '0;
      r_len_err <= 1'b0;
      r_ovf_err <= 1'b0;
      r_fifo_wr <= 1'b0;
      r_wdata <= '0;
      r_tag <= '0;
    end else begin
      r_rdcnt <= rdCnt;
      r_wrcnt <= r_wrcnt + 64'(w_ack);
      r_len_err <= r_len_err | (r_state == S_IDLE && |w_bad);
      r_ovf_err <= r_ovf_err | w_ovf;
      r_fifo_wr <= w_ack;
      r_wdata <= w_ack ? w_data[r_g] : r_wdata;
      r_tag <= w_ack ? r_g : r_tag;
    end
  end
endmodule

// File: tb/tb_ixc_gfifo_sched.sv
// tb_ixc_gfifo_sched: directed plus random checks of ixc_gfifo_sched against a transaction-level model
module tb_ixc_gfifo_sched;
  localparam int NREQ = 4, DW = 64, DEPTH = 256, LENW = 9;
  logic clk = 1'b0;
  logic rstn;
  logic [NREQ-1:0] req_valid, req_dvalid, req_gnt, req_ack;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ*DW-1:0] req_data;
  logic [63:0] rdCnt, wrCnt;
  logic fifo_wr, len_err, ovf_err;
  logic [DW-1:0] fifo_wdata;
  logic [1:0] fifo_tag;
  int len_a [NREQ];
  logic [DW-1:0] data_a [NREQ];
  int sent [NREQ];
  int acks [NREQ];
  int n_tests = 0, n_fail = 0, nwr = 0;
  int order [$];
  logic [NREQ-1:0] ack_seen, prev_gnt;
  int owner, left, rr, m_ftag;
  longint unsigned m_wr, m_rd;
  bit m_fwr, m_lerr, m_oerr;
  logic [63:0] m_fdata;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_len[i*LENW +: LENW] = LENW'(len_a[i]);
    assign req_data[i*DW +: DW] = data_a[i];
  end

  ixc_gfifo_sched #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .LENW(LENW)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_len(req_len),
    .req_dvalid(req_dvalid), .req_data(req_data), .req_gnt(req_gnt), .req_ack(req_ack),
    .rdCnt(rdCnt), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_tag(fifo_tag),
    .wrCnt(wrCnt), .len_err(len_err), .ovf_err(ovf_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    owner = -1; left = 0; rr = 0; m_wr = 0; m_rd = 0;
    m_fwr = 0; m_fdata = '0; m_ftag = 0; m_lerr = 0; m_oerr = 0;
  endtask

  // One clock: compare all outputs with the model, advance the model, then retire acked words
  task automatic step();
    logic [NREQ-1:0] eg;
    longint unsigned occ;
    int free, l;
    bit hit;
    @(negedge clk);
    eg = (owner >= 0) ? NREQ'(1 << owner) : '0;
    chk("gnt", 64'(req_gnt), 64'(eg));
    chk("ack", 64'(req_ack), 64'(eg & req_dvalid));
    chk("fifo_wr", 64'(fifo_wr), 64'(m_fwr));
    chk("wdata", fifo_wdata, m_fdata);
    chk("tag", 64'(fifo_tag), 64'(m_ftag));
    chk("wrCnt", wrCnt, m_wr);
    chk("len_err", 64'(len_err), 64'(m_lerr));
    chk("ovf_err", 64'(ovf_err), 64'(m_oerr));
    if (req_gnt != '0 && prev_gnt == '0)
      for (int i = 0; i < NREQ; i++) if (req_gnt[i]) order.push_back(i);
    prev_gnt = req_gnt;
    if (fifo_wr) nwr++;
    ack_seen = req_ack;
    if (!rstn) model_reset();
    else begin
      occ = m_wr - m_rd;
      free = (occ > 64'(DEPTH)) ? 0 : DEPTH - int'(occ);
      if (occ > 64'(DEPTH)) m_oerr = 1;
      m_fwr = 0;
      if (owner < 0) begin
        for (int i = 0; i < NREQ; i++)
          if (req_valid[i] && (len_a[i] == 0 || len_a[i] > DEPTH)) m_lerr = 1;
        hit = 0;
        for (int k = 0; k < NREQ && !hit; k++) begin
          l = (rr + k) % NREQ;
          if (req_valid[l] && len_a[l] >= 1 && len_a[l] <= free) begin
            owner = l; left = len_a[l]; rr = (l + 1) % NREQ; hit = 1;
          end
        end
      end else if (req_dvalid[owner]) begin
        m_wr++; m_fwr = 1; m_fdata = data_a[owner]; m_ftag = owner;
        if (left == 1) owner = -1; else left--;
      end
      m_rd = rdCnt;
    end
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) if (ack_seen[i]) begin
      acks[i]++; sent[i]++; data_a[i] = rand64();
      if (sent[i] >= len_a[i]) begin req_valid[i] = 1'b0; req_dvalid[i] = 1'b0; end
    end
  endtask

  task automatic run(input int n);
    for (int t = 0; t < n; t++) step();
  endtask

  task automatic request(input int s, input int len);
    req_valid[s] = 1'b1; req_dvalid[s] = 1'b1; len_a[s] = len; sent[s] = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = '0; req_dvalid = '0;
    step(); step();
    rstn = 1'b1;
    order.delete(); nwr = 0;
    for (int i = 0; i < NREQ; i++) begin acks[i] = 0; sent[i] = 0; end
  endtask

  initial begin
    rstn = 1'b0; rdCnt = '0; req_valid = '0; req_dvalid = '0; prev_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin len_a[i] = 0; data_a[i] = rand64(); acks[i] = 0; sent[i] = 0; end
    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk("rst_gnt", 64'(req_gnt), 64'd0);
    chk("rst_fifo_wr", 64'(fifo_wr), 64'd0);
    chk("rst_wrcnt", wrCnt, 64'd0);
    chk("rst_errs", 64'({len_err, ovf_err}), 64'd0);

    // single 4-word burst from source 1
    request(1, 4);
    step();
    chk("single_gnt", 64'(req_gnt), 64'b0010);
    run(5);
    chk("single_acks", 64'(acks[1]), 64'd4);
    chk("single_nwr", 64'(nwr), 64'd4);
    chk("single_wrcnt", wrCnt, 64'd4);
    chk("single_idle", 64'(req_gnt), 64'd0);

    // round robin: 0 and 2 together, then 0 again while 3 is silent
    do_reset();
    request(0, 2); request(2, 2);
    run(8);
    request(0, 2);
    run(5);
    chk("rr_count", 64'(order.size()), 64'd3);
    if (order.size() == 3) begin
      chk("rr_first", 64'(order[0]), 64'd0);
      chk("rr_second", 64'(order[1]), 64'd2);
      chk("rr_third", 64'(order[2]), 64'd0);
    end

    // credit stall: fill the GFIFO, then wait for the host to free 4 words
    do_reset();
    request(0, 256);
    run(260);
    chk("stall_fill", wrCnt, 64'd256);
    request(1, 4);
    run(5);
    chk("stall_nogrant0", 64'(req_gnt), 64'd0);
    rdCnt = 64'd3;
    run(3);
    chk("stall_nogrant3", 64'(req_gnt), 64'd0);
    rdCnt = 64'd4;
    step();
    chk("stall_gnt_k", 64'(req_gnt), 64'd0);
    step();
    chk("stall_gnt_k1", 64'(req_gnt), 64'b0010);
    run(6);
    chk("stall_wrcnt", wrCnt, 64'd260);
    rdCnt = '0;

    // illegal lengths on source 3
    do_reset();
    req_valid[3] = 1'b1; len_a[3] = 0;
    run(3);
    chk("len0_err", 64'(len_err), 64'd1);
    chk("len0_gnt", 64'(req_gnt), 64'd0);
    len_a[3] = 257;
    run(3);
    chk("len257_gnt", 64'(req_gnt), 64'd0);
    req_valid[3] = 1'b0;
    run(3);
    chk("len_err_sticky", 64'(len_err), 64'd1);
    do_reset();
    chk("len_err_clr", 64'(len_err), 64'd0);

    // host anomaly: reads ahead of writes
    rdCnt = 64'd5;
    step();
    request(0, 1); request(2, 3);
    run(4);
    chk("anom_ovf", 64'(ovf_err), 64'd1);
    chk("anom_gnt", 64'(req_gnt), 64'd0);
    chk("anom_wrcnt", wrCnt, 64'd0);
    rdCnt = '0;
    do_reset();
    chk("anom_clr", 64'(ovf_err), 64'd0);

    // reset in the middle of an 8-word burst
    request(2, 8);
    for (int t = 0; t < 20 && acks[2] < 2; t++) step();
    chk("mid_acks", 64'(acks[2]), 64'd2);
    rstn = 1'b0;
    step();
    chk("mid_gnt", 64'(req_gnt), 64'd0);
    chk("mid_fifo_wr", 64'(fifo_wr), 64'd0);
    chk("mid_wdata", fifo_wdata, 64'd0);
    chk("mid_tag", 64'(fifo_tag), 64'd0);
    chk("mid_wrcnt", wrCnt, 64'd0);
    req_valid = '0; req_dvalid = '0; rstn = 1'b1;
    request(0, 1);
    step();
    chk("mid_regnt", 64'(req_gnt), 64'b0001);
    run(3);
    chk("mid_wrcnt1", wrCnt, 64'd1);

    // random traffic with random data gaps, illegal lengths and a slow host
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && (len_a[i] == 0 || len_a[i] > DEPTH) && $urandom % 4 == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom % 6 == 0) begin
          req_valid[i] = 1'b1; sent[i] = 0;
          len_a[i] = ($urandom % 40 == 0) ? (($urandom % 2 == 0) ? 0 : 257) : 1 + int'($urandom % 12);
        end
        req_dvalid[i] = req_valid[i] && ($urandom % 4 != 0);
      end
      if ($urandom % 2 == 0 && rdCnt < m_wr) rdCnt = rdCnt + 64'd1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
